// File: rtl/hazard_pkg.sv
// hazard_pkg: forward selects, stall-cause encoding and timer width shared by the hazard unit
package hazard_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam int MD_CNT_W = 4;
    typedef enum logic [2:0] {NONE, MEM, MD, LW, BR} stall_cause_e;
endpackage

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: HI/LO busy timer, loads MD_LAT-1 on an accepted mult/div and counts down to zero
module hazard_md_timer
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    // reload on accepted start, otherwise drain toward zero regardless of other stalls
    always_comb md_cnt_d = load_i ? MD_CNT_W'(MD_LAT - 1) : (md_cnt_q != '0) ? md_cnt_q - MD_CNT_W'(1) : md_cnt_q;
    // counter register, cleared at once by reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) md_cnt_q <= '0;
        else md_cnt_q <= md_cnt_d;
    assign busy_o = (md_cnt_q != '0);
endmodule

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: forwarding plus load-use, branch, mult/div and memory-wait stall/flush control
// Defining HAZARD_PERF_EN adds saturating stall-cycle counters with perf_clr and perf_* ports.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              mdstartE,
    input  logic              mdreadD,
    input  logic              memreqM,
    input  logic              memreadyM,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              md_busy
`ifdef HAZARD_PERF_EN
    , input  logic              perf_clr
    , output logic [PERF_W-1:0] perf_lw
    , output logic [PERF_W-1:0] perf_br
    , output logic [PERF_W-1:0] perf_md
    , output logic [PERF_W-1:0] perf_mem
`endif
);
    logic lw_stall, br_stall, mem_stall, md_e_stall, md_rd_stall, front_stall;

    // register 0 is hardwired, so it never produces a dependency
    function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    assign forwardAE = (regwriteM && hit(writeregM, rsE)) ? FWD_M : (regwriteW && hit(writeregW, rsE)) ? FWD_W : FWD_RF;
    assign forwardBE = (regwriteM && hit(writeregM, rtE)) ? FWD_M : (regwriteW && hit(writeregW, rtE)) ? FWD_W : FWD_RF;
    assign forwardAD = regwriteM && hit(writeregM, rsD);
    assign forwardBD = regwriteM && hit(writeregM, rtD);

    assign lw_stall    = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));
    assign br_stall    = branchD && ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD)))
                                  || (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
    assign mem_stall   = memreqM && !memreadyM;
    assign md_rd_stall = mdreadD && md_busy;
    assign md_e_stall  = mdstartE && md_busy;
    assign front_stall = lw_stall || br_stall || md_rd_stall;

    // a frozen stage never receives a bubble; the memory wait freezes everything up to M
    assign stallM = mem_stall;
    assign flushW = mem_stall;
    assign stallE = mem_stall || md_e_stall;
    assign flushM = md_e_stall && !mem_stall;
    assign stallD = stallE || front_stall;
    assign stallF = stallD;
    assign flushE = front_stall && !stallE;

    hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (mdstartE && !stallE),
        .busy_o (md_busy)
    );

`ifdef HAZARD_PERF_EN
    stall_cause_e cause;
    logic [3:0] perf_hit;
    logic [3:0][PERF_W-1:0] perf_q, perf_d;
    assign cause = mem_stall ? MEM : (md_e_stall || md_rd_stall) ? MD : lw_stall ? LW : br_stall ? BR : NONE;
    assign perf_hit = {cause == BR, cause == LW, cause == MD, cause == MEM};
    // each stalled cycle bumps only the counter of its dominant cause; clear beats the bump
    always_comb begin
        for (int i = 0; i < 4; i++)
            perf_d[i] = perf_clr ? '0 : (perf_hit[i] && perf_q[i] != '1) ? perf_q[i] + PERF_W'(1) : perf_q[i];
    end
    // counter registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) perf_q <= '0;
        else perf_q <= perf_d;
    assign perf_mem = perf_q[0];
    assign perf_md  = perf_q[1];
    assign perf_lw  = perf_q[2];
    assign perf_br  = perf_q[3];
`endif
endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: directed vectors with a scoreboard queue checked at each falling edge
module tb_hazard_unit_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD;
    logic mdstartE, mdreadD, memreqM, memreadyM;
    logic forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, flushM, flushW, md_busy;
    logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
    logic perf_clr;
    logic [31:0] perf_lw, perf_br, perf_md, perf_mem;
`endif

    typedef struct {
        string       nm;
        logic [13:0] exp;
        bit          perf;
        logic [31:0] p_mem, p_md, p_lw, p_br;
    } sb_t;
    sb_t sb_q[$];
    int checks = 0;
    int errors = 0;
    logic [13:0] act;

    always #5 clk = ~clk;

    hazard_unit_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .mdstartE(mdstartE), .mdreadD(mdreadD), .memreqM(memreqM), .memreadyM(memreadyM),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushM(flushM), .flushW(flushW), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
        , .perf_clr(perf_clr), .perf_lw(perf_lw), .perf_br(perf_br), .perf_md(perf_md), .perf_mem(perf_mem)
`endif
    );

    assign act = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, flushM, flushW, md_busy};

    function automatic logic [13:0] o(input logic [1:0] fae, input logic [1:0] fbe, input logic fad, input logic fbd,
                                      input logic sf, input logic sd, input logic se, input logic sm,
                                      input logic fe, input logic fm, input logic fw, input logic bz);
        return {fae, fbe, fad, fbd, sf, sd, se, sm, fe, fm, fw, bz};
    endfunction

    task automatic idle();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD} = '0;
        {mdstartE, mdreadD, memreqM, memreadyM} = '0;
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b0;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_o(input string nm, input logic [13:0] e);
        sb_t s;
        s.nm = nm; s.exp = e; s.perf = 1'b0;
        s.p_mem = '0; s.p_md = '0; s.p_lw = '0; s.p_br = '0;
        sb_q.push_back(s);
    endtask

    task automatic expect_p(input string nm, input logic [13:0] e, input logic [31:0] pm, input logic [31:0] pd,
                            input logic [31:0] pl, input logic [31:0] pb);
        sb_t s;
        s.nm = nm; s.exp = e; s.perf = 1'b1;
        s.p_mem = pm; s.p_md = pd; s.p_lw = pl; s.p_br = pb;
        sb_q.push_back(s);
    endtask

    // monitor: pops one expectation per cycle and compares away from the rising edge
    always @(negedge clk) begin
        sb_t s;
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: outputs got %b expected %b", s.nm, act, s.exp);
            end
`ifdef HAZARD_PERF_EN
            if (s.perf) begin
                checks++;
                if ({perf_mem, perf_md, perf_lw, perf_br} !== {s.p_mem, s.p_md, s.p_lw, s.p_br}) begin
                    errors++;
                    $display("FAIL %s_perf: mem/md/lw/br got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                             s.nm, perf_mem, perf_md, perf_lw, perf_br, s.p_mem, s.p_md, s.p_lw, s.p_br);
                end
            end
`endif
        end
    end

    localparam logic [13:0] LU  = 14'b00_00_0_0_1_1_0_0_1_0_0_0;
    localparam logic [13:0] MDR = 14'b00_00_0_0_1_1_0_0_1_0_0_1;
    localparam logic [13:0] B2B = 14'b00_00_0_0_1_1_1_0_0_1_0_1;
    localparam logic [13:0] MW  = 14'b00_00_0_0_1_1_1_1_0_0_1_1;
    localparam logic [13:0] MEMO = 14'b00_00_0_0_1_1_1_1_0_0_1_0;

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1; expect_o("reset", '0);
        cyc(); rst_n = 1'b1; expect_o("idle", '0);
        cyc(); memtoregE = 1; rtE = 8; rsD = 8; expect_o("load_use", o(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        cyc(); expect_o("load_use_release", '0);
        cyc(); memtoregE = 1; rtE = 0; rsD = 0; expect_o("load_use_r0", '0);
        cyc(); regwriteM = 1; regwriteW = 1; writeregM = 5; writeregW = 5; rsE = 5;
        expect_o("fwd_m_over_w", o(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); regwriteM = 1; regwriteW = 1; expect_o("fwd_r0", '0);
        cyc(); regwriteW = 1; writeregW = 7; rtE = 7; expect_o("fwd_w", o(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); writeregW = 7; rtE = 7; expect_o("fwd_w_disabled", '0);
        cyc(); regwriteM = 1; writeregM = 9; rsD = 9; rtD = 9; expect_o("fwd_d", o(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; expect_o("br_alu_e", LU);
        cyc(); branchD = 1; memtoregM = 1; writeregM = 4; rsD = 4; expect_o("br_load_m", LU);
        cyc(); branchD = 1; regwriteE = 1; expect_o("br_r0", '0);
        cyc(); mdstartE = 1; expect_o("md_start", '0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); mdreadD = 1; expect_o($sformatf("md_read_%0d", i), MDR);
        end
        cyc(); mdreadD = 1; expect_o("md_read_release", '0);
        cyc(); mdstartE = 1; expect_o("b2b_first", '0);
        cyc(); expect_o("b2b_busy", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); mdstartE = 1; expect_o("b2b_stall_2", B2B);
        cyc(); mdstartE = 1; expect_o("b2b_stall_3", B2B);
        cyc(); mdstartE = 1; expect_o("b2b_accept", '0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); mdreadD = 1; memreqM = 1; expect_o($sformatf("mem_wait_%0d", i), MW);
        end
        cyc(); mdreadD = 1; memreqM = 1; memreadyM = 1; expect_o("mem_done_md_drained", '0);
        cyc(); mdstartE = 1; memreqM = 1; expect_o("md_start_in_mem_wait", MEMO);
        cyc(); expect_o("md_start_not_taken", '0);
        cyc(); mdstartE = 1; expect_o("rst_md_start", '0);
        cyc(); expect_o("rst_md_busy", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); rst_n = 1'b0; expect_o("rst_mid", '0);
        cyc(); rst_n = 1'b1; expect_o("rst_release", '0);
`ifdef HAZARD_PERF_EN
        cyc(); perf_clr = 1; expect_o("perf_clr0", '0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); memreqM = 1; expect_o($sformatf("perf_mem_%0d", i), MEMO);
        end
        cyc(); memtoregE = 1; rtE = 8; rsD = 8; expect_o("perf_lw_1", LU);
        cyc(); memtoregE = 1; rtE = 8; rsD = 8; expect_o("perf_lw_2", LU);
        cyc(); memtoregE = 1; rtE = 8; rsD = 8; perf_clr = 1; expect_p("perf_counts", LU, 3, 0, 2, 0);
        cyc(); expect_p("perf_cleared", '0, 0, 0, 0, 0);
`endif
        @(posedge clk);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending got %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
